perceptron_n: RTL and testbench
===============================

# perceptron_n

Parametrised successor to the three-input perceptron core: an N-input fixed-point perceptron with a serial load port, a sequential multiply-accumulate, and a single-pass learning update. Weights, learning rate and samples are loaded one word per `go` beat; each sample is classified and, when requested, trained on. The block sits behind the same external user pins as the earlier core, widened by parameters, and adds saturating arithmetic and a `busy` indication.

## Interface
- `N_IN`, default 4: number of inputs x1..xN; weights are w0..wN_IN (w0 is the bias).
- `W`, default 8: word width, signed two's complement.
- `FRAC`, default 3: fraction bits; 1.0 = 1<<FRAC.
- `SW`, derived = $clog2(N_IN+3): width of `sel_out`.
- `clk`  in  1  sole clock, rising edge.
- `reset_l`  in  1  asynchronous, active-low reset.
- `go`  in  1  load beat; `in_val` is captured when `go`=1 in a load state.
- `update`  in  1  sampled in CHECK; 1 = train on a misclassified sample.
- `correct`  in  1  target label for the current sample (1 = positive class).
- `sel_out`  in  SW  readback select: 0..N_IN = w[i], N_IN+1 = n, N_IN+2 = acc, other codes = 0.
- `in_val`  in  W  load data.
- `done`  out  1  one-cycle pulse at the end of each sample.
- `classification`  out  1  registered result of the last MAC.
- `sync`  out  1  combinational = `go` in load states; acknowledges capture.
- `busy`  out  1  high in MAC, CHECK, UPD and FIN.
- `out_val`  out  W  combinational readback per `sel_out`.

## Operation
- States: LOAD_W, LOAD_N, LOAD_X, MAC, CHECK, UPD, FIN. An index counter `idx` ($clog2(N_IN+1) bits) is shared by all states.
- LOAD_W: on each `go`, w[idx] <= in_val and idx++. After the beat at idx==N_IN, go to LOAD_N.
- LOAD_N: on `go`, n <= in_val. Go to LOAD_X with idx=0.
- LOAD_X: on each `go`, x[idx] <= in_val. After the beat at idx==N_IN-1, go to MAC with acc <= w0 and idx=0.
- MAC: N_IN cycles. Each cycle acc <= sat_add(acc, fxmul(w[idx+1], x[idx])). On the last cycle go to CHECK; classification <= (final acc > 0), strictly greater.
- CHECK, one cycle:
  - If `update`=0 or classification==`correct`: done=1, go to LOAD_X.
  - Otherwise go to UPD with idx=0.
- UPD: N_IN+1 cycles. w[idx] <= sat_add(w[idx], fxmul(nd, xe)).
  - nd = `correct` ? n : sat_neg(n).
  - xe = 1.0 when idx==0, else x[idx-1].
  - There is exactly one update pass per sample, with no repeat loop.
- FIN: done=1, go to LOAD_X.
- Weights and n persist across samples. Reloading them requires `reset_l`.
- `go` outside load states is ignored, with no capture and no `sync`.
- `update` and `correct` are sampled only in CHECK and UPD and must be stable from the last x beat until `done`.
- Arithmetic rules:
  - fxmul(a,b): full 2W-bit signed product, arithmetic shift right by FRAC (truncation toward −inf), then saturate to [−2^(W−1), 2^(W−1)−1].
  - sat_add: signed W-bit add, clamped to the same range.
  - sat_neg(−2^(W−1)) = 2^(W−1)−1.

## Timing
- Reset values:
  - All registers (w, n, x, acc, idx) are 0; state is LOAD_W.
  - `done`, `classification` and `busy` are 0.
  - `sync` is 0 while `reset_l`=0.
  - `out_val` = 0 for every `sel_out`.
- Let edge t0 be the one that captures the last x. Then:
  - MAC occupies cycles t0+1..t0+N_IN.
  - CHECK is cycle t0+N_IN+1. `done` is high in that cycle when no update occurs.
  - With an update: UPD occupies t0+N_IN+2..t0+2N_IN+2, and FIN (done) is t0+2N_IN+3.
- LOAD_X accepts a `go` in the cycle immediately after `done`.
- `classification` changes only at the MAC→CHECK edge and holds until the next MAC.
- Reset mid-operation (any state) aborts immediately, returns to LOAD_W with all values per reset, and drops `done` and `busy` the same cycle.

## Structure
- Package `perceptron_pkg`:
  - state enum `pstate_t`;
  - `sel_out` code offsets (SEL_N = N_IN+1, SEL_ACC = N_IN+2), expressed as functions of N_IN;
  - localparam ONE = 1<<FRAC convention.
- Sub-module `perceptron_fxmac` (combinational, parameters W and FRAC): inputs a, b, c; output sat_add(c, fxmul(a,b)).
  - It is shared by MAC (c=acc) and UPD (c=w[idx]), so only one multiplier exists.
- Weight and x storage are register arrays indexed by `idx`. The FSM and datapath both live in `perceptron_n`.

## Test plan
All scenarios use N_IN=4, W=8, FRAC=3.
- Reset, then sweep `sel_out` 0..7 -> `out_val`=0 throughout; `done`=`classification`=`busy`=0; `sync` mirrors `go` only in load states.
- w=[8,8,8,8,8], n=4, x=[8,0,0,0], update=0 -> acc=16, classification=1, `done` at t0+5, no weight change.
- w=all 0, n=8, x=[8,16,0,−8], correct=1, update=1 -> classification=0; weights become [8,8,16,0,−8]; `done` at t0+11; `busy` high t0+1..t0+11.
- w0=127, w1=127, others 0, x1=127, update=0 -> acc=127 (saturated), classification=1. Same setup with w0=w1=−128 -> acc=−128.
- `go` held high through MAC/CHECK/UPD -> no capture and `sync`=0 there; `done` is exactly one cycle; the next x is captured the cycle after `done`.
- `reset_l` low during UPD cycle 2 -> all `out_val` readbacks 0 and state LOAD_W; the next `go` with in_val=5 writes w0=5.

Source files
------------

// File: rtl/perceptron_pkg.sv
// Shared types and constants for the N-input fixed-point perceptron.
package perceptron_pkg;

  typedef enum logic [2:0] {
    LOAD_W,
    LOAD_N,
    LOAD_X,
    MAC,
    CHECK,
    UPD,
    FIN
  } pstate_t;

  // Readback codes beyond the weight window w[0..N_IN].
  function automatic int sel_n_code(input int n_in);
    return n_in + 1;
  endfunction

  function automatic int sel_acc_code(input int n_in);
    return n_in + 2;
  endfunction

  // Fixed-point 1.0 for a given number of fraction bits.
  function automatic int one_val(input int frac);
    return 1 << frac;
  endfunction

endpackage

// File: rtl/perceptron_fxmac.sv
// Combinational saturating fixed-point multiply-accumulate: y = sat_add(c, fxmul(a, b)).
module perceptron_fxmac #(
  parameter int W    = 8,
  parameter int FRAC = 3
) (
  input  logic signed [W-1:0] a,
  input  logic signed [W-1:0] b,
  input  logic signed [W-1:0] c,
  output logic signed [W-1:0] y
);

  localparam logic signed [W-1:0]   MAXV  = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0]   MINV  = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [2*W-1:0] PMAXV = (2*W)'(MAXV);
  localparam logic signed [2*W-1:0] PMINV = (2*W)'(MINV);

  logic signed [2*W-1:0] prod;
  logic signed [2*W-1:0] shifted;
  logic signed [W-1:0]   mul_sat;
  logic signed [W:0]     sum;

  always_comb begin
    prod    = (2*W)'(a) * (2*W)'(b);
    // Arithmetic shift truncates toward -inf before clamping.
    shifted = prod >>> FRAC;
    if (shifted > PMAXV) begin
      mul_sat = MAXV;
    end else if (shifted < PMINV) begin
      mul_sat = MINV;
    end else begin
      mul_sat = shifted[W-1:0];
    end
    sum = {c[W-1], c} + {mul_sat[W-1], mul_sat};
    if (sum[W] != sum[W-1]) begin
      y = sum[W] ? MINV : MAXV;
    end else begin
      y = sum[W-1:0];
    end
  end

endmodule

// File: rtl/perceptron_n.sv
// N-input fixed-point perceptron: serial load, sequential MAC, single-pass learning update.
module perceptron_n
  import perceptron_pkg::*;
#(
  parameter int N_IN = 4,
  parameter int W    = 8,
  parameter int FRAC = 3,
  parameter int SW   = $clog2(N_IN + 3)
) (
  input  logic          clk,
  input  logic          reset_l,
  input  logic          go,
  input  logic          update,
  input  logic          correct,
  input  logic [SW-1:0] sel_out,
  input  logic [W-1:0]  in_val,
  output logic          done,
  output logic          classification,
  output logic          sync,
  output logic          busy,
  output logic [W-1:0]  out_val
);

  localparam int IW = $clog2(N_IN + 1);
  localparam logic [IW-1:0]   IDX_LAST_W = IW'(N_IN);
  localparam logic [IW-1:0]   IDX_LAST_X = IW'(N_IN - 1);
  localparam logic [SW-1:0]   SEL_N      = SW'(sel_n_code(N_IN));
  localparam logic [SW-1:0]   SEL_ACC    = SW'(sel_acc_code(N_IN));
  localparam logic signed [W-1:0] ONE    = W'(one_val(FRAC));
  localparam logic signed [W-1:0] MAXV   = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] MINV   = {1'b1, {(W-1){1'b0}}};

  pstate_t             state;
  logic [IW-1:0]       idx;
  logic signed [W-1:0] w [N_IN+1];
  logic signed [W-1:0] x [N_IN];
  logic signed [W-1:0] n;
  logic signed [W-1:0] acc;

  logic signed [W-1:0] w_cur, w_next, x_cur, x_prev;
  logic signed [W-1:0] nd, xe;
  logic signed [W-1:0] op_a, op_b, op_c, fx_y;
  logic                mac_pos;
  logic                no_upd;

  // Index-selected operands built as explicit muxes so no index exceeds its array.
  always_comb begin
    w_cur  = '0;
    w_next = '0;
    x_cur  = '0;
    x_prev = '0;
    for (int unsigned i = 0; i <= N_IN; i++) begin
      if (idx == IW'(i)) w_cur = w[i];
    end
    for (int unsigned i = 1; i <= N_IN; i++) begin
      if (idx == IW'(i - 1)) w_next = w[i];
    end
    for (int unsigned i = 0; i < N_IN; i++) begin
      if (idx == IW'(i))     x_cur  = x[i];
      if (idx == IW'(i + 1)) x_prev = x[i];
    end
  end

  always_comb begin
    nd = correct ? n : ((n == MINV) ? MAXV : -n);
    xe = (idx == '0) ? ONE : x_prev;
    if (state == UPD) begin
      op_a = nd;
      op_b = xe;
      op_c = w_cur;
    end else begin
      op_a = w_next;
      op_b = x_cur;
      op_c = acc;
    end
  end

  perceptron_fxmac #(.W(W), .FRAC(FRAC)) u_fxmac (
    .a(op_a),
    .b(op_b),
    .c(op_c),
    .y(fx_y)
  );

  assign mac_pos = !fx_y[W-1] && (fx_y != '0);
  assign no_upd  = !update || (mac_pos == correct);

  assign sync = reset_l && go &&
                ((state == LOAD_W) || (state == LOAD_N) || (state == LOAD_X));

  always_comb begin
    out_val = '0;
    for (int unsigned i = 0; i <= N_IN; i++) begin
      if (sel_out == SW'(i)) out_val = w[i];
    end
    if (sel_out == SEL_N)   out_val = n;
    if (sel_out == SEL_ACC) out_val = acc;
  end

  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state          <= LOAD_W;
      idx            <= '0;
      n              <= '0;
      acc            <= '0;
      done           <= 1'b0;
      classification <= 1'b0;
      busy           <= 1'b0;
      for (int unsigned i = 0; i <= N_IN; i++) w[i] <= '0;
      for (int unsigned i = 0; i < N_IN; i++)  x[i] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        LOAD_W: if (go) begin
          for (int unsigned i = 0; i <= N_IN; i++) begin
            if (idx == IW'(i)) w[i] <= in_val;
          end
          if (idx == IDX_LAST_W) begin
            idx   <= '0;
            state <= LOAD_N;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        LOAD_N: if (go) begin
          n     <= in_val;
          idx   <= '0;
          state <= LOAD_X;
        end
        LOAD_X: if (go) begin
          for (int unsigned i = 0; i < N_IN; i++) begin
            if (idx == IW'(i)) x[i] <= in_val;
          end
          if (idx == IDX_LAST_X) begin
            idx   <= '0;
            acc   <= w[0];
            busy  <= 1'b1;
            state <= MAC;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        // done is registered, so the CHECK outcome is decided on the last MAC edge.
        MAC: begin
          acc <= fx_y;
          if (idx == IDX_LAST_X) begin
            idx            <= '0;
            classification <= mac_pos;
            done           <= no_upd;
            state          <= CHECK;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        CHECK: begin
          if (!update || (classification == correct)) begin
            busy  <= 1'b0;
            state <= LOAD_X;
          end else begin
            idx   <= '0;
            state <= UPD;
          end
        end
        UPD: begin
          for (int unsigned i = 0; i <= N_IN; i++) begin
            if (idx == IW'(i)) w[i] <= fx_y;
          end
          if (idx == IDX_LAST_W) begin
            idx   <= '0;
            done  <= 1'b1;
            state <= FIN;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        FIN: begin
          busy  <= 1'b0;
          state <= LOAD_X;
        end
        default: state <= LOAD_W;
      endcase
    end
  end

endmodule

// File: tb/tb_perceptron_n.sv
// Directed self-checking bench for perceptron_n with N_IN=4, W=8, FRAC=3.
module tb_perceptron_n;

  localparam int N_IN = 4;
  localparam int W    = 8;
  localparam int FRAC = 3;
  localparam int SW   = 3;

  logic          clk;
  logic          reset_l;
  logic          go;
  logic          update;
  logic          correct;
  logic [SW-1:0] sel_out;
  logic [W-1:0]  in_val;
  logic          done;
  logic          classification;
  logic          sync;
  logic          busy;
  logic [W-1:0]  out_val;

  int n_asserts = 0;
  int n_fail    = 0;
  int wv [5];
  int xv [4];

  perceptron_n #(.N_IN(N_IN), .W(W), .FRAC(FRAC), .SW(SW)) dut (
    .clk(clk),
    .reset_l(reset_l),
    .go(go),
    .update(update),
    .correct(correct),
    .sel_out(sel_out),
    .in_val(in_val),
    .done(done),
    .classification(classification),
    .sync(sync),
    .busy(busy),
    .out_val(out_val)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input int v);
    go     = 1'b1;
    in_val = W'(v);
    cyc();
    go     = 1'b0;
  endtask

  task automatic chk_rd(input string tag, input int sel, input int exp);
    int v;
    sel_out = SW'(sel);
    #1;
    v = int'($signed(out_val));
    chk(tag, v, exp);
  endtask

  task automatic do_reset();
    reset_l = 1'b0;
    cyc();
    reset_l = 1'b1;
    #1;
  endtask

  // Loads w from wv, n, then x from xv; returns in cycle t0+1.
  task automatic load_all(input int nv);
    for (int i = 0; i < 5; i++) beat(wv[i]);
    beat(nv);
    for (int i = 0; i < 4; i++) beat(xv[i]);
  endtask

  initial begin
    reset_l = 1'b0;
    go      = 1'b0;
    update  = 1'b0;
    correct = 1'b0;
    sel_out = '0;
    in_val  = '0;

    // Reset state
    #25;
    for (int s = 0; s < 8; s++) chk_rd("rst_out_val", s, 0);
    chk("rst_done", int'(done), 0);
    chk("rst_class", int'(classification), 0);
    chk("rst_busy", int'(busy), 0);
    go = 1'b1; #1;
    chk("rst_sync_held", int'(sync), 0);
    go = 1'b0;
    @(posedge clk); #1;
    reset_l = 1'b1; #1;
    chk("sync_go0", int'(sync), 0);
    go = 1'b1; #1;
    chk("sync_loadw", int'(sync), 1);
    go = 1'b0; #1;
    for (int s = 0; s < 8; s++) chk_rd("post_rst_out_val", s, 0);

    // Plain classification, no update
    update  = 1'b0;
    correct = 1'b1;
    wv = '{8, 8, 8, 8, 8};
    xv = '{8, 0, 0, 0};
    load_all(4);
    for (int c = 1; c <= 4; c++) begin
      chk("t2_mac_busy", int'(busy), 1);
      chk("t2_mac_done", int'(done), 0);
      cyc();
    end
    chk("t2_done", int'(done), 1);
    chk("t2_class", int'(classification), 1);
    chk_rd("t2_acc", 6, 16);
    cyc();
    chk("t2_done_drop", int'(done), 0);
    chk("t2_busy_drop", int'(busy), 0);
    for (int s = 0; s < 5; s++) chk_rd("t2_w_kept", s, 8);
    chk_rd("t2_n", 5, 4);

    // go held high across a whole sample and into the next one
    go     = 1'b1;
    in_val = 8'sd8;
    #1;
    chk("t5_sync_loadx", int'(sync), 1);
    for (int c = 0; c < 4; c++) cyc();
    for (int c = 1; c <= 4; c++) begin
      chk("t5_mac_sync", int'(sync), 0);
      chk("t5_mac_busy", int'(busy), 1);
      cyc();
    end
    chk("t5_done", int'(done), 1);
    chk("t5_check_sync", int'(sync), 0);
    chk("t5_class", int'(classification), 1);
    chk_rd("t5_acc", 6, 40);
    in_val = -8'sd8;
    cyc();
    chk("t5_done_one_cycle", int'(done), 0);
    chk("t5_sync_after_done", int'(sync), 1);
    for (int c = 0; c < 4; c++) cyc();
    for (int c = 1; c <= 4; c++) begin
      chk("t5_mac2_done", int'(done), 0);
      cyc();
    end
    chk("t5_done2", int'(done), 1);
    chk("t5_class2", int'(classification), 0);
    chk_rd("t5_acc2", 6, -24);
    go = 1'b0;
    cyc();

    // Misclassified sample with training
    do_reset();
    update  = 1'b1;
    correct = 1'b1;
    wv = '{0, 0, 0, 0, 0};
    xv = '{8, 16, 0, -8};
    load_all(8);
    for (int c = 1; c <= 10; c++) begin
      chk("t3_busy", int'(busy), 1);
      chk("t3_done_early", int'(done), 0);
      if (c == 5) chk("t3_class", int'(classification), 0);
      cyc();
    end
    chk("t3_done", int'(done), 1);
    chk("t3_busy_fin", int'(busy), 1);
    cyc();
    chk("t3_done_drop", int'(done), 0);
    chk("t3_busy_drop", int'(busy), 0);
    chk_rd("t3_w0", 0, 8);
    chk_rd("t3_w1", 1, 8);
    chk_rd("t3_w2", 2, 16);
    chk_rd("t3_w3", 3, 0);
    chk_rd("t3_w4", 4, -8);
    chk_rd("t3_acc", 6, 0);

    // Positive saturation
    do_reset();
    update = 1'b0;
    wv = '{127, 127, 0, 0, 0};
    xv = '{127, 0, 0, 0};
    load_all(0);
    for (int c = 0; c < 4; c++) cyc();
    chk("t4p_done", int'(done), 1);
    chk("t4p_class", int'(classification), 1);
    chk_rd("t4p_acc", 6, 127);

    // Negative saturation
    do_reset();
    wv = '{-128, -128, 0, 0, 0};
    load_all(0);
    for (int c = 0; c < 4; c++) cyc();
    chk("t4n_done", int'(done), 1);
    chk("t4n_class", int'(classification), 0);
    chk_rd("t4n_acc", 6, -128);

    // Reset during the second UPD cycle
    do_reset();
    update  = 1'b1;
    correct = 1'b1;
    wv = '{0, 0, 0, 0, 0};
    xv = '{8, 16, 0, -8};
    load_all(8);
    for (int c = 0; c < 6; c++) cyc();
    chk("t6_busy_upd", int'(busy), 1);
    chk_rd("t6_w0_pre", 0, 8);
    reset_l = 1'b0;
    #1;
    chk("t6_done_rst", int'(done), 0);
    chk("t6_busy_rst", int'(busy), 0);
    for (int s = 0; s < 8; s++) chk_rd("t6_out_val_rst", s, 0);
    cyc();
    reset_l = 1'b1;
    #1;
    beat(5);
    chk_rd("t6_w0_reload", 0, 5);
    chk_rd("t6_w1_reload", 1, 0);
    chk("t6_busy_after", int'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
